// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring integer divider. Produces one quotient bit per
//   clock by trial subtraction, with a start/busy/done handshake.
//
//   Handshake: start is sampled only while busy=0 (IDLE). An accepted start
//   captures A and B. busy is high in CALC and FIN. done is a one-cycle pulse
//   in the cycle after FIN, which is the first cycle Y/R/DZ/V hold the new
//   result. Y/R/DZ/V keep that result until the next FIN.
//
//   Optional feature: define DIV_SIGNED_EN for two's-complement operands
//   (truncating division, V flags MIN / -1). Without it the divider is
//   unsigned and V is tied to 0.
//
// Parameters
//   WIDTH     operand, quotient and remainder width (>= 2)
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-high
//   start     division request
//   A, B      dividend, divisor
//   busy      operation in progress (CALC/FIN)
//   done      one-cycle result-valid pulse
//   Y, R      quotient, remainder
//   DZ        divide-by-zero flag
//   V         signed overflow flag
//   dbgState  current FSM state (0 IDLE, 1 CALC, 2 FIN)
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] R,
    output logic             DZ,
    output logic             V,
    output logic [1:0]       dbgState
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } stateT;

    stateT state;
    stateT nextState;

    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    count;
    logic             zeroDiv;

    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             noBorrow;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] yFinal;
    logic [WIDTH-1:0] rFinal;
    logic             vFinal;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = (B == '0) ? FIN : CALC;
            CALC: if (count == CW'(1)) nextState = FIN;
            FIN:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = (state == CALC) || (state == FIN);
        dbgState = state;
    end

    // ---------------- operand magnitudes ----------------
`ifdef DIV_SIGNED_EN
    logic [WIDTH-1:0] bReg;
    // -2^(W-1) maps onto itself, which read unsigned is the correct magnitude.
    assign magA = A[WIDTH-1] ? WIDTH'(-A) : A;
    assign magB = B[WIDTH-1] ? WIDTH'(-B) : B;
`else
    assign magA = A;
    assign magB = B;
`endif

    // ---------------- one restoring step ----------------
    // The partial remainder is shifted into W+1 bits so its top bit is never
    // lost when the divisor uses the full operand range.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = {1'b0, shifted} - {2'b00, divisor};
        noBorrow = ~trial[WIDTH+1];
        remNext  = noBorrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quoNext  = {quo[WIDTH-2:0], noBorrow};
    end

    // ---------------- result formatting ----------------
    always_comb begin
        yFinal = quo;
        rFinal = rem;
        vFinal = 1'b0;
        if (zeroDiv) begin
            yFinal = '1;
            rFinal = aReg;
        end else begin
`ifdef DIV_SIGNED_EN
            // Truncation toward zero: quotient sign is the XOR of operand
            // signs, remainder takes the dividend's sign.
            if (aReg[WIDTH-1] ^ bReg[WIDTH-1]) yFinal = WIDTH'(-quo);
            if (aReg[WIDTH-1])                 rFinal = WIDTH'(-rem);
            vFinal = (aReg == {1'b1, {(WIDTH-1){1'b0}}}) && (bReg == '1);
`endif
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aReg    <= '0;
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            count   <= '0;
            zeroDiv <= 1'b0;
            Y       <= '0;
            R       <= '0;
            DZ      <= 1'b0;
            V       <= 1'b0;
            done    <= 1'b0;
`ifdef DIV_SIGNED_EN
            bReg    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        aReg    <= A;
                        divisor <= magB;
                        quo     <= magA;
                        rem     <= '0;
                        count   <= CW'(WIDTH);
                        zeroDiv <= (B == '0);
`ifdef DIV_SIGNED_EN
                        bReg    <= B;
`endif
                    end
                end
                CALC: begin
                    rem   <= remNext;
                    quo   <= quoNext;
                    count <= count - 1'b1;
                end
                FIN: begin
                    Y    <= yFinal;
                    R    <= rFinal;
                    DZ   <= zeroDiv;
                    V    <= vFinal;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
